// File: rtl/rst_sequencer_pkg.sv
// Shared state encoding for the reset sequencer.
// Values are fixed because other syscon blocks decode them.
package rst_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK  = 3'd0,
      ST_WAIT_READY = 3'd1,
      ST_GAP        = 3'd2,
      ST_RUN        = 3'd3,
      ST_FAULT      = 3'd4
   } state_t;

endpackage

// File: rtl/rst_sequencer_sync2.sv
// Two-flop synchronizer for one asynchronous level into wb_clk_i.
// Latency is 2 cycles. There is no backpressure; the output is a plain level.
module sync2 (
   input  logic wb_clk_i,
   input  logic wb_rst_n_i,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rst_sequencer.sv
// Releases domain resets in index order after clock lock; there is a gap and a ready wait per domain.
// Release happens LOCK_CYCLES+2 cycles after lock. There is no backpressure; a domain that never becomes ready raises a sticky fault.
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int NUM_DOM       = 4,
   parameter int IDX_W         = 2,
   parameter int LOCK_CYCLES   = 16,
   parameter int GAP_CYCLES    = 8,
   parameter int READY_TIMEOUT = 1024,
   parameter int CNT_W         = 16
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n_i,
   input  logic               locked_i,
   input  logic               sw_rst_i,
   input  logic [NUM_DOM-1:0] dom_ready_i,
   output logic [NUM_DOM-1:0] dom_rst_o,
   output logic               seq_done_o,
   output logic               fault_o,
   output logic [IDX_W-1:0]   fault_idx_o
);

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

   logic lock;
   logic swr;

   sync2 u_sync_lock (.wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .d(locked_i), .q(lock));
   sync2 u_sync_swr  (.wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .d(sw_rst_i), .q(swr));

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [NUM_DOM-1:0] dom_rst_nxt;
   logic               seq_done_nxt;
   logic               fault_nxt;
   logic [IDX_W-1:0]   fault_idx_nxt;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state       <= ST_WAIT_LOCK;
         cnt         <= '0;
         idx         <= '0;
         dom_rst_o   <= '1;
         seq_done_o  <= 1'b0;
         fault_o     <= 1'b0;
         fault_idx_o <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         dom_rst_o   <= dom_rst_nxt;
         seq_done_o  <= seq_done_nxt;
         fault_o     <= fault_nxt;
         fault_idx_o <= fault_idx_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      dom_rst_nxt   = dom_rst_o;
      seq_done_nxt  = seq_done_o;
      fault_nxt     = fault_o;
      fault_idx_nxt = fault_idx_o;

      // A software request clears even a sticky fault; loss of lock does not.
      if (swr) begin
         state_nxt     = ST_WAIT_LOCK;
         cnt_nxt       = '0;
         idx_nxt       = '0;
         dom_rst_nxt   = '1;
         seq_done_nxt  = 1'b0;
         fault_nxt     = 1'b0;
         fault_idx_nxt = '0;
      end else if (!lock && (state == ST_WAIT_READY || state == ST_GAP || state == ST_RUN)) begin
         state_nxt    = ST_WAIT_LOCK;
         cnt_nxt      = '0;
         idx_nxt      = '0;
         dom_rst_nxt  = '1;
         seq_done_nxt = 1'b0;
      end else begin
         case (state)
            ST_WAIT_LOCK: begin
               if (!lock) begin
                  cnt_nxt = '0;
               end else if (cnt == LOCK_LAST) begin
                  dom_rst_nxt[0] = 1'b0;
                  cnt_nxt        = '0;
                  idx_nxt        = '0;
                  state_nxt      = ST_WAIT_READY;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_WAIT_READY: begin
               if (dom_ready_i[idx]) begin
                  if (idx == IDX_LAST) begin
                     state_nxt    = ST_RUN;
                     seq_done_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_GAP;
                     cnt_nxt   = '0;
                  end
               end else if (cnt == TO_LAST) begin
                  state_nxt     = ST_FAULT;
                  fault_nxt     = 1'b1;
                  fault_idx_nxt = idx;
                  dom_rst_nxt   = '1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  idx_nxt              = idx + 1'b1;
                  dom_rst_nxt[idx_nxt] = 1'b0;
                  cnt_nxt              = '0;
                  state_nxt            = ST_WAIT_READY;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_RUN, ST_FAULT: begin
            end
            default: begin
               state_nxt    = ST_WAIT_LOCK;
               cnt_nxt      = '0;
               idx_nxt      = '0;
               dom_rst_nxt  = '1;
               seq_done_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed scenarios for rst_sequencer. Expected output changes are queued with their edge number,
// and a negedge monitor pops one entry for every observed output change.
module tb_rst_sequencer;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_n_i;
   logic       locked_i;
   logic       sw_rst_i;
   logic [3:0] dom_ready_i;
   logic [3:0] dom_rst_o;
   logic       seq_done_o;
   logic       fault_o;
   logic [1:0] fault_idx_o;

   always #5 wb_clk_i = ~wb_clk_i;

   rst_sequencer #(
      .NUM_DOM(4), .IDX_W(2), .LOCK_CYCLES(16), .GAP_CYCLES(8),
      .READY_TIMEOUT(64), .CNT_W(16)
   ) dut (
      .wb_clk_i(wb_clk_i),
      .wb_rst_n_i(wb_rst_n_i),
      .locked_i(locked_i),
      .sw_rst_i(sw_rst_i),
      .dom_ready_i(dom_ready_i),
      .dom_rst_o(dom_rst_o),
      .seq_done_o(seq_done_o),
      .fault_o(fault_o),
      .fault_idx_o(fault_idx_o)
   );

   typedef struct {
      int         cyc;
      logic [3:0] rst;
      logic       done;
      logic       flt;
      logic [1:0] fidx;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;

   // Edge number counted from reset release; edge 1 is the first posedge with reset high.
   always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) cyc <= 0;
      else             cyc <= cyc + 1;
   end

   logic [7:0] prev_out;
   logic [7:0] cur_out;
   ev_t        mon_e;

   always @(negedge wb_clk_i) begin
      cur_out = {dom_rst_o, seq_done_o, fault_o, fault_idx_o};
      if (wb_rst_n_i === 1'b1) begin
         if (cur_out !== prev_out) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change edge=%0d got=%h", cyc, cur_out);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.cyc != cyc || cur_out !== {mon_e.rst, mon_e.done, mon_e.flt, mon_e.fidx}) begin
                  n_fail++;
                  $display("FAIL output_change edge=%0d got=%h required edge=%0d value=%h",
                           cyc, cur_out, mon_e.cyc, {mon_e.rst, mon_e.done, mon_e.flt, mon_e.fidx});
               end
            end
         end
         if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_change now=%0d got=%h required edge=%0d value=%h",
                     cyc, cur_out, mon_e.cyc, {mon_e.rst, mon_e.done, mon_e.flt, mon_e.fidx});
         end
      end
      prev_out = cur_out;
   end

   task automatic expect_ev(input int c, input logic [3:0] r, input logic d,
                            input logic f, input logic [1:0] fi);
      ev_t e;
      e.cyc = c; e.rst = r; e.done = d; e.flt = f; e.fidx = fi;
      exp_q.push_back(e);
   endtask

   // Full four-domain release with every ready already high, first release at edge s.
   task automatic push_seq(input int s);
      expect_ev(s,      4'hE, 1'b0, 1'b0, 2'd0);
      expect_ev(s + 9,  4'hC, 1'b0, 1'b0, 2'd0);
      expect_ev(s + 18, 4'h8, 1'b0, 1'b0, 2'd0);
      expect_ev(s + 27, 4'h0, 1'b0, 1'b0, 2'd0);
      expect_ev(s + 28, 4'h0, 1'b1, 1'b0, 2'd0);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge wb_clk_i);
   endtask

   task automatic do_reset(input string name);
      wb_rst_n_i = 1'b0;
      #1;
      n_tests++;
      if ({dom_rst_o, seq_done_o, fault_o, fault_idx_o} !== 8'hF0) begin
         n_fail++;
         $display("FAIL %s_async_reset got=%h required=f0", name,
                  {dom_rst_o, seq_done_o, fault_o, fault_idx_o});
      end
      repeat (3) @(negedge wb_clk_i);
      wb_rst_n_i = 1'b1;
   endtask

   task automatic end_scn(input string name, input int last);
      wait_cyc(last + 5);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog edge=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      wb_rst_n_i  = 1'b1;
      locked_i    = 1'b1;
      sw_rst_i    = 1'b0;
      dom_ready_i = 4'hF;
      #1;

      // Nominal release, then a lock drop in RUN and a full resequence.
      do_reset("por");
      push_seq(18);
      expect_ev(53, 4'hF, 1'b0, 1'b0, 2'd0);
      push_seq(78);
      wait_cyc(50); locked_i = 1'b0;
      wait_cyc(60); locked_i = 1'b1;
      end_scn("nominal_relock", 106);

      // One-cycle lock glitch restarts the lock count.
      #2 do_reset("glitch");
      push_seq(28);
      wait_cyc(9);  locked_i = 1'b0;
      wait_cyc(10); locked_i = 1'b1;
      end_scn("lock_glitch", 56);

      // Domain 2 stuck: fault survives a lock toggle, a software pulse clears it.
      dom_ready_i = 4'b1011;
      #2 do_reset("fault");
      expect_ev(18,  4'hE, 1'b0, 1'b0, 2'd0);
      expect_ev(27,  4'hC, 1'b0, 1'b0, 2'd0);
      expect_ev(36,  4'h8, 1'b0, 1'b0, 2'd0);
      expect_ev(100, 4'hF, 1'b0, 1'b1, 2'd2);
      expect_ev(123, 4'hF, 1'b0, 1'b0, 2'd0);
      push_seq(139);
      wait_cyc(110); locked_i = 1'b0;
      wait_cyc(115); locked_i = 1'b1;
      wait_cyc(120); sw_rst_i = 1'b1;
      wait_cyc(121); sw_rst_i = 1'b0;
      wait_cyc(125); dom_ready_i = 4'hF;
      end_scn("timeout_fault", 167);

      // Software reset held during the gap after domain 1.
      #2 do_reset("swr");
      expect_ev(18, 4'hE, 1'b0, 1'b0, 2'd0);
      expect_ev(27, 4'hC, 1'b0, 1'b0, 2'd0);
      expect_ev(33, 4'hF, 1'b0, 1'b0, 2'd0);
      push_seq(58);
      wait_cyc(30); sw_rst_i = 1'b1;
      wait_cyc(40); sw_rst_i = 1'b0;
      end_scn("sw_reset_gap", 86);

      // Hardware reset between clock edges while waiting for domain 0.
      dom_ready_i = 4'h0;
      #2 do_reset("pre_async");
      expect_ev(18, 4'hE, 1'b0, 1'b0, 2'd0);
      wait_cyc(25);
      n_tests++;
      if (exp_q.size() != 0 || dom_rst_o !== 4'hE) begin
         n_fail++;
         $display("FAIL wait_ready_state got=%h pending=%0d required=e", dom_rst_o, exp_q.size());
      end
      exp_q.delete();
      #2 do_reset("mid_wait_ready");
      dom_ready_i = 4'hF;
      push_seq(18);
      end_scn("after_async", 46);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
